mbus_mem_responder: RTL and testbench

Word-addressed memory responder for the vector unit's 32-bit memory bus, i.e. the target end of the read (ar/r) and write (aw/w/b) channels driven by the vector memory queue. It is used as the on-chip scratchpad behind the queue in simulation and FPGA builds. Read requests are buffered in a request FIFO and served in order from a synchronous word RAM. Writes are committed with byte strobes, and each write receives an in-order response carrying an error flag.

---
 rtl/mbus_mem_responder_if.sv | 54 +++++
 rtl/mbus_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_mbus_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbus_mem_responder_if.sv
// Bus bundle for the vector unit's 32-bit memory bus: read address (ar),
// read data (r), write address (aw), write data (w) and write response (b).
// The master modport is the vector memory queue side, the slave modport is
// the memory responder side.
interface mbus_mem_responder_if #(
    parameter int unsigned MBUS_ADDR_WIDTH = 32,
    parameter int unsigned MBUS_DATA_WIDTH = 32,
    parameter int unsigned MBUS_DW_B       = MBUS_DATA_WIDTH >> 3
);
    // read address channel
    logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr;
    logic                       mbus_ar_valid;
    logic                       mbus_ar_ready;
    // read data channel
    logic [MBUS_DATA_WIDTH-1:0] mbus_r_data;
    logic                       mbus_r_valid;
    logic                       mbus_r_ready;
    // write address channel (a single ready covers aw and w)
    logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr;
    logic                       mbus_aw_valid;
    logic                       mbus_aw_ready;
    // write data channel
    logic [MBUS_DATA_WIDTH-1:0] mbus_w_data;
    logic                       mbus_w_valid;
    logic [MBUS_DW_B-1:0]       mbus_w_strb;
    // write response channel
    logic                       mbus_b_resp;
    logic                       mbus_b_valid;
    logic                       mbus_b_ready;

    modport master (
        output mbus_ar_addr, mbus_ar_valid,
        input  mbus_ar_ready,
        input  mbus_r_data, mbus_r_valid,
        output mbus_r_ready,
        output mbus_aw_addr, mbus_aw_valid,
        input  mbus_aw_ready,
        output mbus_w_data, mbus_w_valid, mbus_w_strb,
        input  mbus_b_resp, mbus_b_valid,
        output mbus_b_ready
    );

    modport slave (
        input  mbus_ar_addr, mbus_ar_valid,
        output mbus_ar_ready,
        output mbus_r_data, mbus_r_valid,
        input  mbus_r_ready,
        input  mbus_aw_addr, mbus_aw_valid,
        output mbus_aw_ready,
        input  mbus_w_data, mbus_w_valid, mbus_w_strb,
        output mbus_b_resp, mbus_b_valid,
        input  mbus_b_ready
    );
endinterface

// File: rtl/mbus_mem_responder.sv
// Word-addressed scratchpad responder for the vector memory bus.
// Reads are queued in a small request FIFO and served in order from a
// synchronous word RAM through a registered read-data stage. Writes commit
// with byte strobes and each one gets an in-order {err} response from a
// response FIFO. Out-of-range or misaligned addresses are flagged as errors:
// reads return zero, writes leave the RAM untouched.
module mbus_mem_responder #(
    parameter int unsigned                MBUS_ADDR_WIDTH = 32,
    parameter int unsigned                MBUS_DATA_WIDTH = 32,
    parameter int unsigned                MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
    parameter int unsigned                MEM_ADDR_BITS   = 10,
    parameter logic [MBUS_ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0,
    parameter int unsigned                RQ_BITS         = 2,
    parameter int unsigned                BQ_BITS         = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mbus_mem_responder_if.slave bus
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_BITS;
    localparam int unsigned RQ_DEPTH  = 1 << RQ_BITS;
    localparam int unsigned BQ_DEPTH  = 1 << BQ_BITS;
    // size of the RAM window in bytes, compared against the base-relative offset
    localparam logic [MBUS_ADDR_WIDTH-1:0] MEM_BYTES = MBUS_ADDR_WIDTH'(64'd4 << MEM_ADDR_BITS);
    localparam logic [RQ_BITS:0] RQ_FULL = (RQ_BITS + 1)'(RQ_DEPTH);
    localparam logic [BQ_BITS:0] BQ_FULL = (BQ_BITS + 1)'(BQ_DEPTH);

    // decoded access: word index plus error flag
    typedef struct packed {
        logic                     err;
        logic [MEM_ADDR_BITS-1:0] idx;
    } dec_t;

    // Map a byte address to a word index; anything outside the window or not
    // word aligned is an error. Comparing the offset (rather than computing
    // BASE_ADDR + size) keeps the check correct when the window ends at the
    // top of the address space.
    function automatic dec_t f_decode(input logic [MBUS_ADDR_WIDTH-1:0] addr);
        dec_t                       d;
        logic [MBUS_ADDR_WIDTH-1:0] off;
        off   = addr - BASE_ADDR;
        d.idx = off[MEM_ADDR_BITS+1:2];
        d.err = (addr < BASE_ADDR) || (off >= MEM_BYTES) || (addr[1:0] != 2'b00);
        return d;
    endfunction

    // ------------------------------------------------------------------
    // storage
    // ------------------------------------------------------------------
    logic [MBUS_DATA_WIDTH-1:0] r_mem    [MEM_DEPTH];
    dec_t                       r_rq_mem [RQ_DEPTH];
    logic                       r_bq_mem [BQ_DEPTH];

    // read request FIFO state
    logic [RQ_BITS-1:0] r_rq_wp;
    logic [RQ_BITS-1:0] r_rq_rp;
    logic [RQ_BITS:0]   r_rq_cnt;
    logic [RQ_BITS:0]   w_rq_cnt_nxt;
    logic               w_rq_full;
    logic               w_rq_empty;
    logic               w_rq_push;
    logic               w_rq_pop;
    dec_t               w_rq_head;

    // read data stage
    logic                       r_r_valid;
    logic [MBUS_DATA_WIDTH-1:0] r_r_data;

    // write path and response FIFO state
    logic [BQ_BITS-1:0] r_bq_wp;
    logic [BQ_BITS-1:0] r_bq_rp;
    logic [BQ_BITS:0]   r_bq_cnt;
    logic [BQ_BITS:0]   w_bq_cnt_nxt;
    logic               w_bq_full;
    logic               w_b_valid;
    logic               w_b_pop;
    logic               w_wr_fire;

    dec_t w_ar_dec;
    dec_t w_aw_dec;

    // ------------------------------------------------------------------
    // decode and handshakes
    // ------------------------------------------------------------------
    assign w_ar_dec   = f_decode(bus.mbus_ar_addr);
    assign w_aw_dec   = f_decode(bus.mbus_aw_addr);

    assign w_rq_full  = (r_rq_cnt == RQ_FULL);
    assign w_rq_empty = (r_rq_cnt == {(RQ_BITS + 1){1'b0}});
    assign w_rq_push  = bus.mbus_ar_valid & ~w_rq_full;
    // the head may move into the data stage when that stage is free or draining
    assign w_rq_pop   = ~w_rq_empty & (~r_r_valid | bus.mbus_r_ready);
    assign w_rq_head  = r_rq_mem[r_rq_rp];

    assign w_bq_full  = (r_bq_cnt == BQ_FULL);
    assign w_b_valid  = (r_bq_cnt != {(BQ_BITS + 1){1'b0}});
    assign w_b_pop    = w_b_valid & bus.mbus_b_ready;
    // rst_n gates the RAM write so a handshake seen in the reset cycle is dropped
    assign w_wr_fire  = rst_n & bus.mbus_aw_valid & bus.mbus_w_valid & ~w_bq_full;

    // ready signals depend only on registered counts
    assign bus.mbus_ar_ready = ~w_rq_full;
    assign bus.mbus_aw_ready = ~w_bq_full;
    assign bus.mbus_r_valid  = r_r_valid;
    assign bus.mbus_r_data   = r_r_data;
    assign bus.mbus_b_valid  = w_b_valid;
    // forced low while empty so stale FIFO contents never show on the bus
    assign bus.mbus_b_resp   = w_b_valid & r_bq_mem[r_bq_rp];

    // ------------------------------------------------------------------
    // read request FIFO
    // ------------------------------------------------------------------

    // next occupancy of the read request FIFO
    always_comb begin
        w_rq_cnt_nxt = r_rq_cnt;
        case ({w_rq_push, w_rq_pop})
            2'b10:   w_rq_cnt_nxt = r_rq_cnt + 1'b1;
            2'b01:   w_rq_cnt_nxt = r_rq_cnt - 1'b1;
            default: w_rq_cnt_nxt = r_rq_cnt;
        endcase
    end

    // store the decoded read request at the write pointer
    always_ff @(posedge clk) begin
        if (w_rq_push) begin
            r_rq_mem[r_rq_wp] <= w_ar_dec;
        end
    end

    // read FIFO pointers/count and the registered read-data stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rq_wp   <= {RQ_BITS{1'b0}};
            r_rq_rp   <= {RQ_BITS{1'b0}};
            r_rq_cnt  <= {(RQ_BITS + 1){1'b0}};
            r_r_valid <= 1'b0;
            r_r_data  <= {MBUS_DATA_WIDTH{1'b0}};
        end else begin
            r_rq_cnt <= w_rq_cnt_nxt;
            if (w_rq_push) begin
                r_rq_wp <= r_rq_wp + 1'b1;
            end
            if (w_rq_pop) begin
                r_rq_rp   <= r_rq_rp + 1'b1;
                r_r_valid <= 1'b1;
                // RAM is sampled before this edge's write lands: read-first
                r_r_data  <= w_rq_head.err ? {MBUS_DATA_WIDTH{1'b0}} : r_mem[w_rq_head.idx];
            end else if (bus.mbus_r_ready) begin
                r_r_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // write path
    // ------------------------------------------------------------------

    // byte-strobed commit of in-range writes; RAM contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_aw_dec.err) begin
            for (int i = 0; i < int'(MBUS_DW_B); i++) begin
                if (bus.mbus_w_strb[i]) begin
                    r_mem[w_aw_dec.idx][8*i +: 8] <= bus.mbus_w_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // write response FIFO
    // ------------------------------------------------------------------

    // next occupancy of the response FIFO; push and pop together hold the count
    always_comb begin
        w_bq_cnt_nxt = r_bq_cnt;
        case ({w_wr_fire, w_b_pop})
            2'b10:   w_bq_cnt_nxt = r_bq_cnt + 1'b1;
            2'b01:   w_bq_cnt_nxt = r_bq_cnt - 1'b1;
            default: w_bq_cnt_nxt = r_bq_cnt;
        endcase
    end

    // store the error flag of each accepted write
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_bq_mem[r_bq_wp] <= w_aw_dec.err;
        end
    end

    // response FIFO pointers and count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bq_wp  <= {BQ_BITS{1'b0}};
            r_bq_rp  <= {BQ_BITS{1'b0}};
            r_bq_cnt <= {(BQ_BITS + 1){1'b0}};
        end else begin
            r_bq_cnt <= w_bq_cnt_nxt;
            if (w_wr_fire) begin
                r_bq_wp <= r_bq_wp + 1'b1;
            end
            if (w_b_pop) begin
                r_bq_rp <= r_bq_rp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mbus_mem_responder.sv
// Self-checking bench for mbus_mem_responder: a vector table of single
// transactions with hand-computed expectations, plus hand-written sequences
// for latency, read-first, streaming, backpressure, full FIFOs and reset.
// Expected read data / write responses are queued when the request is
// accepted and compared when the DUT presents the beat.
module tb_mbus_mem_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NV   = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mbus_mem_responder_if #(.MBUS_ADDR_WIDTH(32), .MBUS_DATA_WIDTH(32), .MBUS_DW_B(4)) bus ();

    mbus_mem_responder #(
        .MBUS_ADDR_WIDTH(32),
        .MBUS_DATA_WIDTH(32),
        .MBUS_DW_B      (4),
        .MEM_ADDR_BITS  (10),
        .BASE_ADDR      (BASE),
        .RQ_BITS        (2),
        .BQ_BITS        (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] exp_r[$];
    logic        exp_b[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: compare every read beat and write response as it is taken
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mbus_r_valid === 1'b1 && bus.mbus_r_ready === 1'b1) begin
                if (exp_r.size() == 0) chk("r_spurious", {31'b0, bus.mbus_r_valid}, 32'd0);
                else chk("r_data", bus.mbus_r_data, exp_r.pop_front());
            end
            if (bus.mbus_b_valid === 1'b1 && bus.mbus_b_ready === 1'b1) begin
                if (exp_b.size() == 0) chk("b_spurious", {31'b0, bus.mbus_b_valid}, 32'd0);
                else chk("b_resp", {31'b0, bus.mbus_b_resp}, {31'b0, exp_b.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mbus_ar_valid = 1'b0;
        bus.mbus_aw_valid = 1'b0;
        bus.mbus_w_valid  = 1'b0;
    endtask

    // present a read and hold it until accepted; leaves ar_valid high
    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        int t;
        t = 0;
        bus.mbus_ar_addr  = a;
        bus.mbus_ar_valid = 1'b1;
        @(negedge clk);
        while (bus.mbus_ar_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.mbus_ar_ready !== 1'b1) chk("ar_timeout", {31'b0, bus.mbus_ar_ready}, 32'd1);
        else exp_r.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // present a write and hold it until accepted; leaves aw/w valid high
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic e);
        int t;
        t = 0;
        bus.mbus_aw_addr  = a;
        bus.mbus_w_data   = d;
        bus.mbus_w_strb   = s;
        bus.mbus_aw_valid = 1'b1;
        bus.mbus_w_valid  = 1'b1;
        @(negedge clk);
        while (bus.mbus_aw_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.mbus_aw_ready !== 1'b1) chk("aw_timeout", {31'b0, bus.mbus_aw_ready}, 32'd1);
        else exp_b.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) until every queued expectation has been consumed
    task automatic drain();
        int t;
        t = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 200) begin
            step(1);
            t++;
        end
        chk("drain", 32'(exp_r.size() + exp_b.size()), 32'd0);
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_1010, 32'hA5A5_0001, 4'hF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[3]  = '{1'b1, 32'h0000_1020, 32'h0000_1200, 4'h2, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_1020, 32'h0000_0000, 4'h0, 32'hFFFF_12FF};
        vecs[5]  = '{1'b1, 32'h0000_1024, 32'h0000_0000, 4'hF, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h0000_1024, 32'hAABB_CCDD, 4'h9, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'h0000_1024, 32'h0000_0000, 4'h0, 32'hAA00_00DD};
        vecs[8]  = '{1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 4'hF, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0001};
        vecs[10] = '{1'b1, 32'h0000_1002, 32'hDEAD_BEEF, 4'hF, 32'h0000_0001};
        vecs[11] = '{1'b1, 32'h0000_1012, 32'hDEAD_BEEF, 4'hF, 32'h0000_0001};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF, 32'h0000_0001};
        vecs[13] = '{1'b0, 32'h0000_1002, 32'h0000_0000, 4'h0, 32'h0000_0000};
        vecs[14] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, 32'h0000_0000};
        vecs[15] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h0000_0000};
        vecs[16] = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'hA5A5_0001};
        vecs[17] = '{1'b0, 32'h0000_1FFC, 32'h0000_0000, 4'h0, 32'h0BAD_F00D};

        bus.mbus_ar_addr  = 32'h0;
        bus.mbus_aw_addr  = 32'h0;
        bus.mbus_w_data   = 32'h0;
        bus.mbus_w_strb   = 4'h0;
        bus.mbus_r_ready  = 1'b0;
        bus.mbus_b_ready  = 1'b0;
        idle();

        // ---------------- reset state ----------------
        step(3);
        rst_n = 1'b1;
        chk("rst_ar_ready", {31'b0, bus.mbus_ar_ready}, 32'd1);
        chk("rst_aw_ready", {31'b0, bus.mbus_aw_ready}, 32'd1);
        chk("rst_r_valid",  {31'b0, bus.mbus_r_valid},  32'd0);
        chk("rst_r_data",   bus.mbus_r_data,            32'd0);
        chk("rst_b_valid",  {31'b0, bus.mbus_b_valid},  32'd0);
        chk("rst_b_resp",   {31'b0, bus.mbus_b_resp},   32'd0);
        bus.mbus_r_ready = 1'b1;
        bus.mbus_b_ready = 1'b1;
        step(1);

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp[0]);
            else rd(vecs[i].addr, vecs[i].exp);
            idle();
            drain();
        end

        // ---------------- latencies ----------------
        chk("b_idle", {31'b0, bus.mbus_b_valid}, 32'd0);
        wr(32'h0000_1030, 32'h1111_2222, 4'hF, 1'b0);
        chk("b_lat_n1", {31'b0, bus.mbus_b_valid}, 32'd1);
        idle();
        drain();
        rd(32'h0000_1030, 32'h1111_2222);
        idle();
        chk("r_lat_n1", {31'b0, bus.mbus_r_valid}, 32'd0);
        step(1);
        chk("r_lat_n2", {31'b0, bus.mbus_r_valid}, 32'd1);
        drain();

        // ---------------- read-first on same-cycle pop and write ----------------
        wr(32'h0000_1040, 32'h0101_0101, 4'hF, 1'b0);
        idle();
        drain();
        rd(32'h0000_1040, 32'h0101_0101);
        bus.mbus_ar_valid = 1'b0;
        wr(32'h0000_1040, 32'h0202_0202, 4'hF, 1'b0);
        idle();
        drain();
        rd(32'h0000_1040, 32'h0202_0202);
        idle();
        drain();

        // ---------------- 8 back-to-back reads ----------------
        for (int i = 0; i < 8; i++) wr(32'h0000_1100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0);
        idle();
        drain();
        for (int i = 0; i < 8; i++) begin
            rd(32'h0000_1100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            if (i >= 1) chk("rd_stream", {31'b0, bus.mbus_r_valid}, 32'd1);
        end
        idle();
        step(1);
        chk("rd_stream_last", {31'b0, bus.mbus_r_valid}, 32'd1);
        step(1);
        chk("rd_stream_end", {31'b0, bus.mbus_r_valid}, 32'd0);
        drain();

        // ---------------- read backpressure and full request FIFO ----------------
        bus.mbus_r_ready = 1'b0;
        for (int i = 0; i < 5; i++) rd(32'h0000_1100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        chk("ar_full", {31'b0, bus.mbus_ar_ready}, 32'd0);
        bus.mbus_ar_addr = 32'h0000_1114;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("r_hold_valid", {31'b0, bus.mbus_r_valid}, 32'd1);
            chk("r_hold_data", bus.mbus_r_data, 32'hC0DE_0000);
            chk("ar_full_hold", {31'b0, bus.mbus_ar_ready}, 32'd0);
        end
        bus.mbus_r_ready = 1'b1;
        step(1);
        chk("ar_ready_rise", {31'b0, bus.mbus_ar_ready}, 32'd1);
        rd(32'h0000_1114, 32'hC0DE_0005);
        idle();
        drain();

        // ---------------- full response FIFO ----------------
        bus.mbus_b_ready = 1'b0;
        wr(32'h0000_1200, 32'h1111_1111, 4'hF, 1'b0);
        wr(32'h0000_2000, 32'h2222_2222, 4'hF, 1'b1);
        wr(32'h0000_1204, 32'h3333_3333, 4'hF, 1'b0);
        wr(32'h0000_1202, 32'h4444_4444, 4'hF, 1'b1);
        chk("aw_full", {31'b0, bus.mbus_aw_ready}, 32'd0);
        chk("b_head_valid", {31'b0, bus.mbus_b_valid}, 32'd1);
        chk("b_head_resp", {31'b0, bus.mbus_b_resp}, 32'd0);
        fork
            wr(32'h0000_1208, 32'h5555_5555, 4'hF, 1'b0);
            begin
                step(2);
                chk("aw_full_hold", {31'b0, bus.mbus_aw_ready}, 32'd0);
                bus.mbus_b_ready = 1'b1;
                step(1);
                chk("aw_ready_rise", {31'b0, bus.mbus_aw_ready}, 32'd1);
            end
        join
        idle();
        drain();
        rd(32'h0000_1200, 32'h1111_1111);
        rd(32'h0000_1204, 32'h3333_3333);
        rd(32'h0000_1208, 32'h5555_5555);
        idle();
        drain();

        // ---------------- aw without w and w without aw ----------------
        bus.mbus_aw_addr  = 32'h0000_1300;
        bus.mbus_w_data   = 32'h7777_7777;
        bus.mbus_w_strb   = 4'hF;
        bus.mbus_aw_valid = 1'b1;
        step(3);
        chk("aw_only", {31'b0, bus.mbus_b_valid}, 32'd0);
        bus.mbus_aw_valid = 1'b0;
        bus.mbus_w_valid  = 1'b1;
        step(3);
        chk("w_only", {31'b0, bus.mbus_b_valid}, 32'd0);
        idle();
        step(2);
        chk("half_hs_none", {31'b0, bus.mbus_b_valid}, 32'd0);

        // ---------------- reset with reads and a response pending ----------------
        bus.mbus_r_ready = 1'b0;
        bus.mbus_b_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd(32'h0000_1100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        bus.mbus_ar_valid = 1'b0;
        wr(32'h0000_1300, 32'h8888_8888, 4'hF, 1'b0);
        // handshakes offered during the reset cycle must be ignored
        bus.mbus_ar_addr  = 32'h0000_1100;
        bus.mbus_ar_valid = 1'b1;
        bus.mbus_aw_addr  = 32'h0000_1010;
        bus.mbus_w_data   = 32'hBAD0_BAD0;
        bus.mbus_aw_valid = 1'b1;
        bus.mbus_w_valid  = 1'b1;
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_r_valid",  {31'b0, bus.mbus_r_valid},  32'd0);
        chk("mid_rst_r_data",   bus.mbus_r_data,            32'd0);
        chk("mid_rst_ar_ready", {31'b0, bus.mbus_ar_ready}, 32'd1);
        chk("mid_rst_aw_ready", {31'b0, bus.mbus_aw_ready}, 32'd1);
        chk("mid_rst_b_valid",  {31'b0, bus.mbus_b_valid},  32'd0);
        exp_r.delete();
        exp_b.delete();
        idle();
        rst_n = 1'b1;
        bus.mbus_r_ready = 1'b1;
        bus.mbus_b_ready = 1'b1;
        step(10);
        chk("post_rst_no_beat", {31'b0, bus.mbus_r_valid}, 32'd0);
        chk("post_rst_no_resp", {31'b0, bus.mbus_b_valid}, 32'd0);
        rd(32'h0000_1010, 32'hA5A5_0001);
        idle();
        drain();

        chk("queues_empty", 32'(exp_r.size() + exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
